// File: rtl/rv_pipe_pkg.sv
// Shared definitions for the RV32IM pipeline control blocks: FSM state
// encoding, register-address width and the hard-wired zero register.
package rv_pipe_pkg;

    typedef enum logic {
        ST_RUN    = 1'b0,
        ST_MULDIV = 1'b1
    } pipe_state_e;

    localparam int REG_ADDR_W = 5;

    localparam logic [REG_ADDR_W-1:0] REG_X0 = '0;

endpackage

// File: rtl/hazard_detect.sv
// Load-use comparator: flags an ID instruction that reads the register a load
// in EX is about to write. x0 never creates a dependency.
module hazard_detect
    import rv_pipe_pkg::*;
#(
    parameter int AW = 5
) (
    input  logic [AW-1:0] ID_RS1,
    input  logic [AW-1:0] ID_RS2,
    input  logic          ID_USES_RS1,
    input  logic          ID_USES_RS2,
    input  logic [AW-1:0] EX_RD,
    input  logic          EX_MEMREAD,
    output logic          LOAD_USE
);

    logic rs1_hit;
    logic rs2_hit;

    assign rs1_hit  = ID_USES_RS1 && (ID_RS1 == EX_RD);
    assign rs2_hit  = ID_USES_RS2 && (ID_RS2 == EX_RD);
    assign LOAD_USE = EX_MEMREAD && (EX_RD != AW'(REG_X0)) && (rs1_hit || rs2_hit);

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the five-stage pipeline: data-memory freeze,
// multi-cycle DIV/REM hold, branch flush, load-use stall and fetch busywait.
module pipeline_hazard_ctrl
    import rv_pipe_pkg::*;
#(
    parameter int MULDIV_LAT = 4,
    parameter int REG_ADDR_W = rv_pipe_pkg::REG_ADDR_W
) (
    input  logic                  CLK,
    input  logic                  RESET,
    input  logic                  IMEM_BUSYWAIT,
    input  logic                  DMEM_BUSYWAIT,
    input  logic [REG_ADDR_W-1:0] ID_RS1,
    input  logic [REG_ADDR_W-1:0] ID_RS2,
    input  logic                  ID_USES_RS1,
    input  logic                  ID_USES_RS2,
    input  logic                  ID_MULDIV,
    input  logic [REG_ADDR_W-1:0] EX_RD,
    input  logic                  EX_MEMREAD,
    input  logic                  EX_BRANCH_TAKEN,
    output logic                  PC_HOLD,
    output logic                  IF_ID_HOLD,
    output logic                  IF_ID_FLUSH,
    output logic                  ID_EX_HOLD,
    output logic                  ID_EX_BUBBLE,
    output logic                  EX_MEM_HOLD,
    output logic                  EX_MEM_BUBBLE,
    output logic                  MEM_WB_HOLD,
    output logic                  MULDIV_BUSY,
    output logic [31:0]           STALL_CNT
);

    // Entering MULDIV with CNT=LAT-2 gives LAT-1 held cycles in EX.
    localparam logic [3:0] CNT_INIT = (MULDIV_LAT > 1) ? 4'(MULDIV_LAT - 2) : 4'd0;

    pipe_state_e state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] stall_cnt;
    logic        load_use;

    hazard_detect #(.AW(REG_ADDR_W)) u_hazard_detect (
        .ID_RS1      (ID_RS1),
        .ID_RS2      (ID_RS2),
        .ID_USES_RS1 (ID_USES_RS1),
        .ID_USES_RS2 (ID_USES_RS2),
        .EX_RD       (EX_RD),
        .EX_MEMREAD  (EX_MEMREAD),
        .LOAD_USE    (load_use)
    );

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q <= ST_RUN;
            cnt_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        PC_HOLD       = 1'b0;
        IF_ID_HOLD    = 1'b0;
        IF_ID_FLUSH   = 1'b0;
        ID_EX_HOLD    = 1'b0;
        ID_EX_BUBBLE  = 1'b0;
        EX_MEM_HOLD   = 1'b0;
        EX_MEM_BUBBLE = 1'b0;
        MEM_WB_HOLD   = 1'b0;
        if (DMEM_BUSYWAIT) begin
            PC_HOLD     = 1'b1;
            IF_ID_HOLD  = 1'b1;
            ID_EX_HOLD  = 1'b1;
            EX_MEM_HOLD = 1'b1;
            MEM_WB_HOLD = 1'b1;
        end else if (state_q == ST_MULDIV) begin
            PC_HOLD    = 1'b1;
            IF_ID_HOLD = 1'b1;
            ID_EX_HOLD = 1'b1;
            // The final MULDIV cycle lets the quotient/remainder into EX/MEM.
            if (cnt_q != 4'd0) begin
                EX_MEM_BUBBLE = 1'b1;
                cnt_d         = cnt_q - 4'd1;
            end else begin
                state_d = ST_RUN;
            end
        end else if (EX_BRANCH_TAKEN) begin
            IF_ID_FLUSH  = 1'b1;
            ID_EX_BUBBLE = 1'b1;
        end else if (load_use) begin
            PC_HOLD      = 1'b1;
            IF_ID_HOLD   = 1'b1;
            ID_EX_BUBBLE = 1'b1;
        end else begin
            if (IMEM_BUSYWAIT) begin
                PC_HOLD     = 1'b1;
                IF_ID_FLUSH = 1'b1;
            end
            if (ID_MULDIV && (MULDIV_LAT > 1)) begin
                state_d = ST_MULDIV;
                cnt_d   = CNT_INIT;
            end
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            stall_cnt <= 32'd0;
        end else if (PC_HOLD && (stall_cnt != 32'hFFFF_FFFF)) begin
            stall_cnt <= stall_cnt + 32'd1;
        end
    end

    assign MULDIV_BUSY = (state_q == ST_MULDIV);
    assign STALL_CNT   = stall_cnt;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed and randomized bench for pipeline_hazard_ctrl at MULDIV_LAT=4 and 1,
// compared each cycle against a cycle-count reference model.
module tb_pipeline_hazard_ctrl;

    logic       CLK = 1'b0;
    logic       RESET;
    logic       IMEM_BUSYWAIT, DMEM_BUSYWAIT;
    logic [4:0] ID_RS1, ID_RS2, EX_RD;
    logic       ID_USES_RS1, ID_USES_RS2, ID_MULDIV, EX_MEMREAD, EX_BRANCH_TAKEN;

    logic [8:0]  ctrl_a, ctrl_b;
    logic [31:0] stall_a, stall_b;

    int n_total = 0;
    int n_pass  = 0;

    // Model: rem = remaining DIV/REM hold cycles, stall = PC_HOLD cycle count
    int          rem   [2];
    logic [31:0] stall [2];
    int          lat   [2] = '{4, 1};

    always #5 CLK = ~CLK;

    pipeline_hazard_ctrl #(.MULDIV_LAT(4)) u_dut4 (
        .CLK(CLK), .RESET(RESET),
        .IMEM_BUSYWAIT(IMEM_BUSYWAIT), .DMEM_BUSYWAIT(DMEM_BUSYWAIT),
        .ID_RS1(ID_RS1), .ID_RS2(ID_RS2),
        .ID_USES_RS1(ID_USES_RS1), .ID_USES_RS2(ID_USES_RS2),
        .ID_MULDIV(ID_MULDIV), .EX_RD(EX_RD), .EX_MEMREAD(EX_MEMREAD),
        .EX_BRANCH_TAKEN(EX_BRANCH_TAKEN),
        .PC_HOLD(ctrl_a[8]), .IF_ID_HOLD(ctrl_a[7]), .IF_ID_FLUSH(ctrl_a[6]),
        .ID_EX_HOLD(ctrl_a[5]), .ID_EX_BUBBLE(ctrl_a[4]), .EX_MEM_HOLD(ctrl_a[3]),
        .EX_MEM_BUBBLE(ctrl_a[2]), .MEM_WB_HOLD(ctrl_a[1]), .MULDIV_BUSY(ctrl_a[0]),
        .STALL_CNT(stall_a)
    );

    pipeline_hazard_ctrl #(.MULDIV_LAT(1)) u_dut1 (
        .CLK(CLK), .RESET(RESET),
        .IMEM_BUSYWAIT(IMEM_BUSYWAIT), .DMEM_BUSYWAIT(DMEM_BUSYWAIT),
        .ID_RS1(ID_RS1), .ID_RS2(ID_RS2),
        .ID_USES_RS1(ID_USES_RS1), .ID_USES_RS2(ID_USES_RS2),
        .ID_MULDIV(ID_MULDIV), .EX_RD(EX_RD), .EX_MEMREAD(EX_MEMREAD),
        .EX_BRANCH_TAKEN(EX_BRANCH_TAKEN),
        .PC_HOLD(ctrl_b[8]), .IF_ID_HOLD(ctrl_b[7]), .IF_ID_FLUSH(ctrl_b[6]),
        .ID_EX_HOLD(ctrl_b[5]), .ID_EX_BUBBLE(ctrl_b[4]), .EX_MEM_HOLD(ctrl_b[3]),
        .EX_MEM_BUBBLE(ctrl_b[2]), .MEM_WB_HOLD(ctrl_b[1]), .MULDIV_BUSY(ctrl_b[0]),
        .STALL_CNT(stall_b)
    );

    function automatic logic model_load_use();
        return EX_MEMREAD && (EX_RD != 5'd0) &&
               ((ID_USES_RS1 && ID_RS1 == EX_RD) || (ID_USES_RS2 && ID_RS2 == EX_RD));
    endfunction

    // Order: pc_hold, ifid_hold, ifid_flush, idex_hold, idex_bubble,
    //        exmem_hold, exmem_bubble, memwb_hold, muldiv_busy
    function automatic logic [8:0] model_ctrl(input int r);
        logic [8:0] c;
        c    = '0;
        c[0] = (r > 0);
        if (RESET) return 9'd0;
        if (DMEM_BUSYWAIT) begin
            c[8] = 1'b1; c[7] = 1'b1; c[5] = 1'b1; c[3] = 1'b1; c[1] = 1'b1;
        end else if (r > 0) begin
            c[8] = 1'b1; c[7] = 1'b1; c[5] = 1'b1;
            c[2] = (r > 1);
        end else if (EX_BRANCH_TAKEN) begin
            c[6] = 1'b1; c[4] = 1'b1;
        end else if (model_load_use()) begin
            c[8] = 1'b1; c[7] = 1'b1; c[4] = 1'b1;
        end else if (IMEM_BUSYWAIT) begin
            c[8] = 1'b1; c[6] = 1'b1;
        end
        return c;
    endfunction

    task automatic model_clock();
        for (int k = 0; k < 2; k++) begin
            logic [8:0] c;
            c = model_ctrl(rem[k]);
            if (c[8] && stall[k] != 32'hFFFF_FFFF) stall[k] = stall[k] + 32'd1;
            if (DMEM_BUSYWAIT) begin
                // frozen
            end else if (rem[k] > 0) begin
                rem[k] = rem[k] - 1;
            end else if (ID_MULDIV && !EX_BRANCH_TAKEN && !model_load_use()) begin
                rem[k] = lat[k] - 1;
            end
        end
    endtask

    task automatic check_vec(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic check_all(input string tag);
        #1;
        check_vec({tag, "/ctrl_lat4"}, {23'd0, ctrl_a}, {23'd0, model_ctrl(rem[0])});
        check_vec({tag, "/ctrl_lat1"}, {23'd0, ctrl_b}, {23'd0, model_ctrl(rem[1])});
        check_vec({tag, "/stall_lat4"}, stall_a, stall[0]);
        check_vec({tag, "/stall_lat1"}, stall_b, stall[1]);
    endtask

    task automatic step(input string tag);
        check_all(tag);
        @(posedge CLK);
        model_clock();
        @(negedge CLK);
    endtask

    task automatic idle();
        IMEM_BUSYWAIT = 0; DMEM_BUSYWAIT = 0; ID_RS1 = 0; ID_RS2 = 0;
        ID_USES_RS1 = 0; ID_USES_RS2 = 0; ID_MULDIV = 0; EX_RD = 0;
        EX_MEMREAD = 0; EX_BRANCH_TAKEN = 0;
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            rem[k]   = 0;
            stall[k] = 32'd0;
        end
    endtask

    initial begin
        idle();
        RESET = 1'b1;
        model_reset();
        @(negedge CLK);
        @(negedge CLK);
        check_all("in_reset");
        RESET = 1'b0;
        step("reset_idle");

        // load-use on rs2, then same pattern with EX_RD = x0
        EX_MEMREAD = 1; EX_RD = 5; ID_RS2 = 5; ID_USES_RS2 = 1;
        step("load_use");
        idle();
        step("after_load_use");
        EX_MEMREAD = 1; EX_RD = 0; ID_RS2 = 0; ID_USES_RS2 = 1;
        step("load_x0");

        // load-use and taken branch together
        EX_MEMREAD = 1; EX_RD = 7; ID_RS1 = 7; ID_USES_RS1 = 1; EX_BRANCH_TAKEN = 1;
        step("branch_over_lu");
        idle();
        IMEM_BUSYWAIT = 1;
        step("imem_wait");

        // DIV/REM entry together with fetch busywait, then full occupancy
        ID_MULDIV = 1;
        step("muldiv_entry");
        idle();
        for (int i = 0; i < 4; i++) step("muldiv_run");

        // DMEM freeze for 3 cycles inside MULDIV
        ID_MULDIV = 1;
        step("muldiv_entry2");
        idle();
        step("muldiv_pre_freeze");
        DMEM_BUSYWAIT = 1;
        for (int i = 0; i < 3; i++) step("muldiv_freeze");
        DMEM_BUSYWAIT = 0;
        EX_BRANCH_TAKEN = 1;
        for (int i = 0; i < 3; i++) step("muldiv_post_freeze");
        idle();

        // reset mid-MULDIV drops the holds immediately
        ID_MULDIV = 1;
        step("muldiv_entry3");
        idle();
        step("muldiv_before_reset");
        RESET = 1'b1;
        model_reset();
        check_all("reset_mid_muldiv");
        @(negedge CLK);
        RESET = 1'b0;
        step("after_reset");

        // saturation of the stall counter
        force u_dut4.stall_cnt = 32'hFFFF_FFFE;
        #1;
        release u_dut4.stall_cnt;
        stall[0] = 32'hFFFF_FFFE;
        IMEM_BUSYWAIT = 1;
        for (int i = 0; i < 3; i++) step("stall_sat");
        idle();
        step("stall_sat_hold");

        // randomized traffic
        for (int i = 0; i < 600; i++) begin
            DMEM_BUSYWAIT   = ($urandom_range(0, 7) == 0);
            EX_BRANCH_TAKEN = ($urandom_range(0, 7) == 0);
            IMEM_BUSYWAIT   = ($urandom_range(0, 3) == 0);
            ID_MULDIV       = ($urandom_range(0, 4) == 0);
            EX_MEMREAD      = $urandom_range(0, 1) == 1;
            EX_RD           = 5'($urandom_range(0, 3));
            ID_RS1          = 5'($urandom_range(0, 3));
            ID_RS2          = 5'($urandom_range(0, 3));
            ID_USES_RS1     = $urandom_range(0, 1) == 1;
            ID_USES_RS2     = $urandom_range(0, 1) == 1;
            step("random");
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
